// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the UART-to-Wishbone debug bridge: sub-codes, ASCII
// character constants and the command-decoder state type.
package wb_bridge_pkg;

  localparam int unsigned CmdWidth = 34;

  localparam logic [1:0] SubRd      = 2'b00;
  localparam logic [1:0] SubWr      = 2'b01;
  localparam logic [1:0] SubAddr    = 2'b10;
  localparam logic [1:0] SubSpecial = 2'b11;

  localparam logic [7:0] ChR     = 8'h52;
  localparam logic [7:0] ChW     = 8'h57;
  localparam logic [7:0] ChA     = 8'h41;
  localparam logic [7:0] ChZ     = 8'h5a;
  localparam logic [7:0] ChLf    = 8'h0a;
  localparam logic [7:0] ChCr    = 8'h0d;
  localparam logic [7:0] ChSpace = 8'h20;
  localparam logic [7:0] Ch0     = 8'h30;
  localparam logic [7:0] Ch9     = 8'h39;
  localparam logic [7:0] ChLa    = 8'h61;
  localparam logic [7:0] ChLf_f  = 8'h66;

  typedef enum logic [0:0] {
    StIdle,
    StArg
  } dec_state_e;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO; accepts a push while full when a pop happens in
// the same cycle, otherwise a push while full is dropped and flagged.
module wb_cmd_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign o_empty    = (wr_ptr_q == rd_ptr_q);
  assign o_full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign do_pop     = i_pop && !o_empty;
  assign do_push    = i_push && (!o_full || do_pop);
  assign o_overflow = i_push && o_full && !do_pop;
  assign o_data     = o_empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/wb_cmd_decoder.sv
// ASCII command decoder feeding the Wishbone master through a small FIFO.
// Optional CMD_DEC_RESET_CMD_EN: 'Z' aborts and pushes a SPECIAL bus-reset word.
module wb_cmd_decoder
  import wb_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_stb,
  input  logic [7:0]          i_byte,
  output logic                o_cmd_stb,
  output logic [CmdWidth-1:0] o_cmd_word,
  input  logic                i_cmd_busy,
  output logic                o_err
);

  function automatic logic [3:0] nibble(input logic [7:0] b);
    logic [7:0] t;
    if (b <= Ch9) t = b - Ch0;
    else          t = b - 8'h57;
    return t[3:0];
  endfunction

  dec_state_e          state_q, state_d;
  logic [1:0]          cmd_sub_q, cmd_sub_d;
  logic [31:0]         acc_q, acc_d;
  logic                push_q, push_d;
  logic [CmdWidth-1:0] push_word_q, push_word_d;
  logic                err_q, err_d;

  logic is_digit, is_term, is_space, is_reset_cmd;
  logic fifo_empty, fifo_full, fifo_overflow, fifo_pop;

  assign is_digit = ((i_byte >= Ch0) && (i_byte <= Ch9)) ||
                    ((i_byte >= ChLa) && (i_byte <= ChLf_f));
  assign is_term  = (i_byte == ChLf) || (i_byte == ChCr);
  assign is_space = (i_byte == ChSpace);
`ifdef CMD_DEC_RESET_CMD_EN
  assign is_reset_cmd = (i_byte == ChZ);
`else
  assign is_reset_cmd = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      cmd_sub_q   <= SubRd;
      acc_q       <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_sub_q   <= cmd_sub_d;
      acc_q       <= acc_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      err_q       <= err_d | fifo_overflow;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_stb) begin
      unique case (state_q)
        StIdle: if ((i_byte == ChW) || (i_byte == ChA)) state_d = StArg;
        StArg:  if (!is_digit && !is_space) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cmd_sub_d   = cmd_sub_q;
    acc_d       = acc_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    err_d       = 1'b0;
    if (i_stb) begin
      unique case (state_q)
        StIdle: begin
          if (i_byte == ChR) begin
            push_d      = 1'b1;
            push_word_d = {SubRd, 32'h0};
          end else if (i_byte == ChW) begin
            cmd_sub_d = SubWr;
            acc_d     = '0;
          end else if (i_byte == ChA) begin
            cmd_sub_d = SubAddr;
            acc_d     = '0;
          end else if (is_reset_cmd) begin
            push_d      = 1'b1;
            push_word_d = {SubSpecial, 32'h0};
          end else if (!is_term && !is_space) begin
            err_d = 1'b1;
          end
        end
        StArg: begin
          if (is_digit) begin
            acc_d = {acc_q[27:0], nibble(i_byte)};
          end else if (is_term) begin
            push_d      = 1'b1;
            push_word_d = {cmd_sub_q, acc_q};
          end else if (is_reset_cmd) begin
            push_d      = 1'b1;
            push_word_d = {SubSpecial, 32'h0};
            acc_d       = '0;
          end else if (!is_space) begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_pop  = !fifo_empty && !i_cmd_busy;
  assign o_cmd_stb = !fifo_empty;
  assign o_err     = err_q;

  wb_cmd_fifo #(
    .WIDTH(CmdWidth),
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_push     (push_q),
    .i_data     (push_word_q),
    .i_pop      (fifo_pop),
    .o_data     (o_cmd_word),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_overflow (fifo_overflow)
  );

endmodule

// File: tb/tb_wb_cmd_decoder.sv
// Scoreboard bench for wb_cmd_decoder: directed byte strings, expected words
// queued at issue time and checked by an independent monitor.
module tb_wb_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        busy = 1'b0;
  logic        cmd_stb;
  logic [33:0] cmd_word;
  logic        err;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int exp_err = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  wb_cmd_decoder #(.DEPTH(4)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_stb      (stb),
    .i_byte     (byte_in),
    .o_cmd_stb  (cmd_stb),
    .o_cmd_word (cmd_word),
    .i_cmd_busy (busy),
    .o_err      (err)
  );

  // Head word is checked every presented cycle; popped only when not busy.
  always @(negedge clk) begin
    if (rst_n && cmd_stb) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL word_unexpected got=%h required=none", cmd_word);
      end else begin
        if (cmd_word !== exp_q[0]) begin
          failures++;
          $display("FAIL word got=%h required=%h", cmd_word, exp_q[0]);
        end
        if (!busy) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) if (err) err_seen++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    stb = 1'b1;
    byte_in = b;
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stb", cmd_stb, 0);
    chk("reset_word", cmd_word, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;
    settle(1);

    // "R\n": word visible two edges after 'R' is sampled.
    exp_q.push_back(34'h0_0000_0000);
    send_byte(8'h52);
    chk("r_latency_early", cmd_stb, 0);
    settle(1);
    chk("r_latency", cmd_stb, 1);
    send_str("\n");
    settle(3);
    chk("r_err", err_seen, exp_err);

    exp_q.push_back({2'b10, 32'h1234abcd});
    send_str("A1234abcd\r");
    exp_q.push_back({2'b01, 32'h23456789});
    send_str("W123456789\n");
    settle(4);

    // Overflow: five reads while busy, only four fit.
    busy = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(34'h0);
    exp_err++;
    send_str("RRRRR");
    settle(4);
    chk("ovf_err", err_seen, exp_err);
    chk("ovf_held", cmd_stb, 1);
    busy = 1'b0;
    settle(4);
    chk("ovf_drained", cmd_stb, 0);

    // Syntax error in ARG.
    send_byte(8'h57);
    send_byte(8'h78);
    chk("wx_err_pulse", err, 1);
    settle(1);
    chk("wx_err_one_cycle", err, 0);
    exp_err++;
    exp_q.push_back({2'b01, 32'h5});
    send_str("W5\n");
    settle(4);
    chk("wx_err", err_seen, exp_err);

    // Full FIFO with simultaneous push and pop.
    busy = 1'b1;
    exp_q.push_back({2'b10, 32'h1});
    exp_q.push_back({2'b10, 32'h2});
    exp_q.push_back({2'b10, 32'h3});
    exp_q.push_back({2'b10, 32'h4});
    exp_q.push_back({2'b10, 32'h5});
    send_str("A1\nA2\nA3\nA4\nA5");
    settle(2);
    stb = 1'b1;
    byte_in = 8'h0a;
    @(posedge clk);
    #1;
    stb = 1'b0;
    busy = 1'b0;
    @(posedge clk);
    #1;
    busy = 1'b1;
    settle(3);
    chk("full_pushpop_err", err_seen, exp_err);
    chk("full_pushpop_held", cmd_stb, 1);
    busy = 1'b0;
    settle(4);
    chk("full_pushpop_drained", cmd_stb, 0);

    // Reset mid-command while holding two words.
    busy = 1'b1;
    send_str("RR");
    exp_q.push_back(34'h0);
    exp_q.push_back(34'h0);
    settle(2);
    send_str("A12");
    rst_n = 1'b0;
    #1;
    chk("midreset_stb", cmd_stb, 0);
    chk("midreset_word", cmd_word, 0);
    exp_q.delete();
    settle(1);
    rst_n = 1'b1;
    busy = 1'b0;
    settle(1);
    exp_err++;
    send_str("5\n");
    settle(4);
    chk("postreset_err", err_seen, exp_err);
    chk("postreset_nopush", cmd_stb, 0);

`ifdef CMD_DEC_RESET_CMD_EN
    exp_q.push_back({2'b11, 32'h0});
`else
    exp_err++;
`endif
    send_str("A1Z");
    settle(4);
    chk("z_err", err_seen, exp_err);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_stb", cmd_stb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
